// File: rtl/gear_mode_ctrl.sv
// -----------------------------------------------------------------------------
// gear_mode_ctrl
//
// P-R-N-D gear selector that feeds the mode seven-segment display driver.
// It debounces the raw shift-up and shift-down pushbuttons. It then steps a
// selector FSM whose state register is the display mode code directly:
// 0 = N, 1 = P, 2 = R, 3 = D.
//
// Optional feature (compile-time macro N_BLINK_EN):
//   When defined, leading_zero blinks while the selector is in N. Its
//   half-period is BLINK_CYCLES clock cycles.
//   When undefined, no blink counter exists and leading_zero is tied low.
//
// Parameters:
//   DEBOUNCE_CYCLES : consecutive stable cycles before a button level is
//                     accepted (minimum 2).
//   BLINK_CYCLES    : half-period of the N blink (minimum 2, N_BLINK_EN only).
//
// Ports:
//   clk          in   system clock, rising edge
//   reset        in   synchronous active-high reset
//   btn_up       in   raw shift-up button (asynchronous), moves toward P
//   btn_down     in   raw shift-down button (asynchronous), moves toward D
//   brake        in   brake pedal pressed (synchronous level)
//   speed_zero   in   vehicle stationary (synchronous level)
//   mode         out  gear code for the display
//   leading_zero out  blanks the '0' digit when high
//   shift_err    out  one-cycle pulse after a rejected shift request
//   state_dbg    out  raw FSM state register, for checkers
//
// Handshake: there is no valid/ready pair in this block. A button press
// becomes a single-cycle event pulse. The FSM consumes that pulse in the
// cycle it is high, and there is no back-pressure.
// -----------------------------------------------------------------------------
module gear_mode_ctrl #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int BLINK_CYCLES    = 25000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       brake,
    input  logic       speed_zero,
    output logic [1:0] mode,
    output logic       leading_zero,
    output logic       shift_err,
    output logic [1:0] state_dbg
);

    if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
        $error("DEBOUNCE_CYCLES must be at least 2");
    end
    if (BLINK_CYCLES < 2) begin : g_bad_blink
        $error("BLINK_CYCLES must be at least 2");
    end

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    // Encoding chosen so the state register is the display code itself.
    typedef enum logic [1:0] {
        S_N = 2'd0,
        S_P = 2'd1,
        S_R = 2'd2,
        S_D = 2'd3
    } state_t;

    // Bit 0 = up button, bit 1 = down button.
    logic [1:0]    raw;
    logic [1:0]    sync1_q, sync2_q;
    logic [1:0]    deb_q, deb_d;
    logic [1:0]    deb_prev_q;
    logic [1:0]    evt_q;
    logic [CW-1:0] cnt_q [2];
    logic [CW-1:0] cnt_d [2];

    assign raw = {btn_down, btn_up};

    // The level is accepted on the cycle the mismatch run would reach
    // DEBOUNCE_CYCLES. That cycle updates the level and clears the counter.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            cnt_d[i] = cnt_q[i];
            deb_d[i] = deb_q[i];
            if (sync2_q[i] == deb_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
                deb_d[i] = sync2_q[i];
                cnt_d[i] = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            deb_q      <= '0;
            deb_prev_q <= '0;
            evt_q      <= '0;
            for (int i = 0; i < 2; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q    <= raw;
            sync2_q    <= sync1_q;
            deb_q      <= deb_d;
            deb_prev_q <= deb_q;
            // Rising edge of the debounced level only, so a release or a
            // long hold produces no further events.
            evt_q      <= deb_q & ~deb_prev_q;
            for (int i = 0; i < 2; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // Selector FSM
    // ------------------------------------------------------------------
    state_t state_q, state_d, target;
    logic   err_q, err_d;

    always_comb begin
        state_d = state_q;
        err_d   = 1'b0;
        target  = state_q;
        if (evt_q[0] && evt_q[1]) begin
            // Conflicting requests: neither is honoured.
            err_d = 1'b1;
        end else if (evt_q[0] || evt_q[1]) begin
            if (evt_q[0]) begin
                case (state_q)
                    S_D:     target = S_N;
                    S_N:     target = S_R;
                    S_R:     target = S_P;
                    default: target = state_q;
                endcase
            end else begin
                case (state_q)
                    S_P:     target = S_R;
                    S_R:     target = S_N;
                    S_N:     target = S_D;
                    default: target = state_q;
                endcase
            end
            // A press at a range end has no target and is silently dropped.
            // Interlocks apply only to real moves.
            if (target != state_q) begin
                if (!speed_zero || (state_q == S_P && !brake)) begin
                    err_d = 1'b1;
                end else begin
                    state_d = target;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_P;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
        end
    end

    assign mode      = state_q;
    assign state_dbg = state_q;
    assign shift_err = err_q;

`ifdef N_BLINK_EN
    localparam int BW = $clog2(BLINK_CYCLES);

    logic [BW-1:0] blink_q, blink_d;
    logic          lz_q, lz_d;

    // Next state is used so that leading_zero drops on the same edge that
    // the selector leaves N, and the counter restarts cleanly on entry.
    always_comb begin
        blink_d = blink_q;
        lz_d    = lz_q;
        if (state_d != S_N || state_q != S_N) begin
            blink_d = '0;
            lz_d    = 1'b0;
        end else if (blink_q == BW'(BLINK_CYCLES - 1)) begin
            blink_d = '0;
            lz_d    = ~lz_q;
        end else begin
            blink_d = blink_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            blink_q <= '0;
            lz_q    <= 1'b0;
        end else begin
            blink_q <= blink_d;
            lz_q    <= lz_d;
        end
    end

    assign leading_zero = lz_q;
`else
    assign leading_zero = 1'b0;
`endif

endmodule
